alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Consumer end of the 16-bit ALU result interface. It accepts completed results (bitwise, add/sub, shift) from the EX-stage ALU over a valid/ready handshake and holds them in a two-entry elastic buffer. It presents them in order to the MEM stage and drives a forwarding port back to the EX operand muxes. It decouples ALU issue from MEM-stage stalls without a combinational ready path.

## Interface
- DATA_W, 16, result width
- REG_W, 3, destination register address width
- OP_W, 3, ALU opcode width, carried through for MEM-stage decode
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  ALU result available
- in_ready  out  1  stage can accept; registered
- in_result  in  DATA_W  ALU result
- in_rd  in  REG_W  destination register
- in_wb_en  in  1  result is written back
- in_op  in  OP_W  originating opcode
- flush  in  1  synchronous squash of all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM stage accepts head
- out_result  out  DATA_W  head result
- out_rd  out  REG_W  head destination
- out_wb_en  out  1  head write-back enable
- out_op  out  OP_W  head opcode
- out_zero  out  1  head result == 0
- fwd_valid  out  1  youngest held entry has wb_en=1
- fwd_rd  out  REG_W  youngest entry destination
- fwd_result  out  DATA_W  youngest entry result

## Operation
- Storage: head slot H and skid slot S. Each holds result, rd, wb_en, op and zero. Zero is computed at write time, never from the output.
- State: EMPTY (0 entries), ONE (H valid), FULL (H and S valid).
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept writes H and goes to ONE.
- ONE:
  - accept and no drain: write S, go to FULL.
  - accept with drain: overwrite H, stay ONE.
  - drain only: go to EMPTY.
- FULL:
  - drain: S moves to H, go to ONE. in_ready is 0, so no accept is possible.
- in_ready = (state != FULL), decoded from registered state only.
- out_valid = (state != EMPTY). Head fields are stable while out_valid & !out_ready.
- Forwarding selects S when FULL and H when ONE. fwd_valid = youngest.wb_en & (state != EMPTY).
- flush wins over everything. Next state is EMPTY. A same-cycle accept is discarded and a same-cycle drain still counts at MEM.
- Entries with in_wb_en=0 are buffered and drained normally.
- Reset values: state EMPTY, in_ready 1, out_valid 0, out_result 0, out_rd 0, out_wb_en 0, out_op 0, out_zero 0, fwd_valid 0, fwd_rd 0, fwd_result 0.
- Reset asserted mid-transfer drops all entries immediately. There is no partial output.

## Timing
- Latency: an accept at edge N gives out_valid and head fields valid after edge N.
- Throughput: one result per cycle with out_ready held high. Never enters FULL.
- One stall cycle (out_ready=0) with in_valid=1 fills S. in_ready is low the next cycle.
- Recovery: the first cycle with out_ready=1 after FULL returns in_ready=1 at the following edge.
- No combinational path from out_ready or in_valid to in_ready.
- All outputs are registered or decoded from registered state only.

## Structure
- Shared package alu_pkg: DATA_W, REG_W and OP_W constants, the entry record typedef (result, rd, wb_en, op, zero), and the state enum {EMPTY, ONE, FULL}.
- One sub-module, result_skid2, which holds the two-slot buffer and state machine. The top level adds zero detection and forwarding select.

## Test plan
- Reset then idle: all outputs 0, in_ready=1. Push result 0x00F0, rd=3, wb_en=1 -> next cycle out_valid=1, out_result=0x00F0, out_zero=0, fwd_valid=1, fwd_rd=3.
- Streaming: 8 back-to-back results 0x0001..0x0008 with out_ready=1 -> drained in order, one per cycle, in_ready never 0.
- Stall fill: out_ready=0, push 0xAAAA then 0x5555 -> FULL, in_ready=0, out_result=0xAAAA, fwd_result=0x5555. A third push is held off. Release out_ready -> 0xAAAA, 0x5555, third value in order.
- Zero flag and no-writeback: push 0x0000 with wb_en=0 -> out_zero=1, fwd_valid=0, entry drains normally.
- Flush while FULL with simultaneous in_valid=1 (0x1234) -> next cycle EMPTY, out_valid=0, in_ready=1, 0x1234 never appears.
- Async reset asserted mid-stall between clock edges -> outputs go to reset values before the next edge. After release, the first push appears one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: field widths, the buffered
// entry record and the elastic-buffer occupancy states.
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 3;
   localparam int OP_W   = 3;

   // One completed ALU result as it travels towards the MEM stage.
   // The zero flag is captured alongside the result when it is written.
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [REG_W-1:0]  rd;
      logic              wb_en;
      logic [OP_W-1:0]   op;
      logic              zero;
   } alu_entry_t;

   // Occupancy of the two-slot buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   // Builds an entry from raw ALU outputs, deriving the zero flag.
   function automatic alu_entry_t make_entry(
      input logic [DATA_W-1:0] result,
      input logic [REG_W-1:0]  rd,
      input logic              wb_en,
      input logic [OP_W-1:0]   op
   );
      alu_entry_t e;
      e.result = result;
      e.rd     = rd;
      e.wb_en  = wb_en;
      e.op     = op;
      e.zero   = (result == '0);
      return e;
   endfunction

endpackage

// File: rtl/result_skid2.sv
// Two-slot elastic buffer (head H plus skid S) with its occupancy state
// machine. Ready towards the producer is decoded from the state register
// only, so there is no combinational path from the consumer back upstream.
module result_skid2
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  alu_entry_t  in_entry,
   input  logic        out_ready,
   output skid_state_t state,
   output alu_entry_t  head,
   output alu_entry_t  skid
);

   logic accept;
   logic drain;

   // Handshake qualifiers derived from registered state and the inputs.
   always_comb begin
      in_ready = (state != FULL);
      accept   = in_valid & (state != FULL);
      drain    = (state != EMPTY) & out_ready;
   end

   // Occupancy FSM and slot storage; flush empties the buffer and discards
   // any same-cycle accept, while slot contents are simply left stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  head  <= in_entry;
                  state <= ONE;
               end
            end
            ONE: begin
               if (accept && !drain) begin
                  skid  <= in_entry;
                  state <= FULL;
               end else if (accept && drain) begin
                  head  <= in_entry;
               end else if (drain) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  head  <= skid;
                  state <= ONE;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Consumer end of the ALU result interface. Buffers completed results in a
// two-entry elastic buffer, presents them in order to the MEM stage and
// offers the youngest held result to the EX operand forwarding muxes.
module alu_result_stage
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_wb_en,
   input  logic [OP_W-1:0]   in_op,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_wb_en,
   output logic [OP_W-1:0]   out_op,
   output logic              out_zero,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_rd,
   output logic [DATA_W-1:0] fwd_result
);

   alu_entry_t  in_entry;
   alu_entry_t  head;
   alu_entry_t  skid;
   alu_entry_t  youngest;
   skid_state_t state;

   // Pack the incoming result and compute its zero flag at write time.
   always_comb begin
      in_entry = make_entry(in_result, in_rd, in_wb_en, in_op);
   end

   result_skid2 u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_entry  (in_entry),
      .out_ready (out_ready),
      .state     (state),
      .head      (head),
      .skid      (skid)
   );

   // Head slot drives the MEM-stage outputs; validity comes from state.
   always_comb begin
      out_valid  = (state != EMPTY);
      out_result = head.result;
      out_rd     = head.rd;
      out_wb_en  = head.wb_en;
      out_op     = head.op;
      out_zero   = head.zero;
   end

   // Forward the youngest held entry: skid when full, otherwise head.
   always_comb begin
      youngest   = (state == FULL) ? skid : head;
      fwd_valid  = youngest.wb_en & (state != EMPTY);
      fwd_rd     = youngest.rd;
      fwd_result = youngest.result;
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage: reset, single push,
// streaming, stall fill, zero/no-writeback, flush and asynchronous reset.
module tb_alu_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [2:0]  in_rd;
   logic        in_wb_en;
   logic [2:0]  in_op;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_rd;
   logic        out_wb_en;
   logic [2:0]  out_op;
   logic        out_zero;
   logic        fwd_valid;
   logic [2:0]  fwd_rd;
   logic [15:0] fwd_result;

   int checks;
   int errors;

   alu_result_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_rd      (in_rd),
      .in_wb_en   (in_wb_en),
      .in_op      (in_op),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd     (out_rd),
      .out_wb_en  (out_wb_en),
      .out_op     (out_op),
      .out_zero   (out_zero),
      .fwd_valid  (fwd_valid),
      .fwd_rd     (fwd_rd),
      .fwd_result (fwd_result)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish, required finish before 100000");
      $fatal(1, "[TB] timeout");
   end

   // Counts one comparison and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives the producer-side inputs.
   task automatic applyStimulus(input logic v, input logic [15:0] res, input logic [2:0] rd,
                                input logic wb, input logic [2:0] op);
      in_valid  = v;
      in_result = res;
      in_rd     = rd;
      in_wb_en  = wb;
      in_op     = op;
   endtask

   // Advances one clock edge and settles 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 3'd0);

      // Reset and idle
      step();
      step();
      rst_n = 1'b1;
      step();
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_result", out_result, 0);
      checkOutput("rst_out_rd", out_rd, 0);
      checkOutput("rst_out_zero", out_zero, 0);
      checkOutput("rst_fwd_valid", fwd_valid, 0);
      checkOutput("rst_fwd_result", fwd_result, 0);

      // Single push
      applyStimulus(1'b1, 16'h00F0, 3'd3, 1'b1, 3'd2);
      step();
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 3'd0);
      checkOutput("push_out_valid", out_valid, 1);
      checkOutput("push_out_result", out_result, 16'h00F0);
      checkOutput("push_out_op", out_op, 2);
      checkOutput("push_out_zero", out_zero, 0);
      checkOutput("push_fwd_valid", fwd_valid, 1);
      checkOutput("push_fwd_rd", fwd_rd, 3);
      step();
      checkOutput("push_held", out_result, 16'h00F0);
      out_ready = 1'b1;
      step();
      checkOutput("push_drained", out_valid, 0);

      // Streaming with out_ready held high
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 16'(i), 3'(i), 1'b1, 3'd1);
         checkOutput($sformatf("stream_in_ready_%0d", i), in_ready, 1);
         step();
         checkOutput($sformatf("stream_valid_%0d", i), out_valid, 1);
         checkOutput($sformatf("stream_result_%0d", i), out_result, 32'(i));
      end
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 3'd0);
      step();
      checkOutput("stream_empty", out_valid, 0);

      // Stall fill
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'hAAAA, 3'd1, 1'b1, 3'd3);
      step();
      checkOutput("fill_one_in_ready", in_ready, 1);
      applyStimulus(1'b1, 16'h5555, 3'd2, 1'b1, 3'd4);
      step();
      checkOutput("fill_full_in_ready", in_ready, 0);
      checkOutput("fill_out_result", out_result, 16'hAAAA);
      checkOutput("fill_fwd_result", fwd_result, 16'h5555);
      checkOutput("fill_fwd_rd", fwd_rd, 2);
      applyStimulus(1'b1, 16'h7777, 3'd5, 1'b1, 3'd5);
      step();
      checkOutput("fill_third_held_off", in_ready, 0);
      checkOutput("fill_head_stable", out_result, 16'hAAAA);
      out_ready = 1'b1;
      step();
      checkOutput("drain_second", out_result, 16'h5555);
      checkOutput("drain_in_ready", in_ready, 1);
      step();
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 3'd0);
      checkOutput("drain_third", out_result, 16'h7777);
      checkOutput("drain_third_rd", out_rd, 5);
      step();
      checkOutput("drain_empty", out_valid, 0);

      // Zero result without write-back
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h0000, 3'd6, 1'b0, 3'd0);
      step();
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 3'd0);
      checkOutput("zero_out_valid", out_valid, 1);
      checkOutput("zero_out_zero", out_zero, 1);
      checkOutput("zero_out_wb_en", out_wb_en, 0);
      checkOutput("zero_fwd_valid", fwd_valid, 0);
      out_ready = 1'b1;
      step();
      checkOutput("zero_drained", out_valid, 0);

      // Flush while full with a simultaneous push
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h1111, 3'd1, 1'b1, 3'd0);
      step();
      applyStimulus(1'b1, 16'h2222, 3'd2, 1'b1, 3'd0);
      step();
      checkOutput("flush_pre_full", in_ready, 0);
      applyStimulus(1'b1, 16'h1234, 3'd4, 1'b1, 3'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 3'd0);
      checkOutput("flush_out_valid", out_valid, 0);
      checkOutput("flush_in_ready", in_ready, 1);
      checkOutput("flush_fwd_valid", fwd_valid, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput($sformatf("flush_no_1234_%0d", i), out_valid & (out_result == 16'h1234), 0);
      end

      // Asynchronous reset mid-stall
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h9999, 3'd1, 1'b1, 3'd1);
      step();
      applyStimulus(1'b1, 16'h8888, 3'd2, 1'b1, 3'd2);
      step();
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 3'd0);
      checkOutput("areset_pre_full", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("areset_out_valid", out_valid, 0);
      checkOutput("areset_in_ready", in_ready, 1);
      checkOutput("areset_out_result", out_result, 0);
      checkOutput("areset_out_op", out_op, 0);
      checkOutput("areset_fwd_valid", fwd_valid, 0);
      checkOutput("areset_fwd_result", fwd_result, 0);
      step();
      rst_n = 1'b1;
      applyStimulus(1'b1, 16'hABCD, 3'd7, 1'b1, 3'd6);
      step();
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 3'd0);
      checkOutput("post_reset_valid", out_valid, 1);
      checkOutput("post_reset_result", out_result, 16'hABCD);
      checkOutput("post_reset_fwd_rd", fwd_rd, 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
